redmule_x_feeder: RTL and testbench

- Upstream neighbour of the X buffer: accepts X-matrix beats from the streamer over a valid/ready handshake and buffers them in a 2-entry skid.
- Applies column-leftover zero masking and issues one X-buffer load strobe per row.
- Counts rows per tile. After each tile, holds until the scheduler signals the tile was consumed, then refills.
- Raises done after the configured number of tiles.

---
 rtl/redmule_x_feeder_pkg.sv | 41 ++++
 rtl/redmule_x_skid.sv | 61 ++++++
 rtl/redmule_x_feeder.sv | 181 ++++++++++++++++++
 tb/tb_redmule_x_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_x_feeder_pkg.sv
// Shared types and constants for the RedMulE X-matrix feeder and its skid buffer.
package redmule_x_feeder_pkg;

   typedef enum logic [1:0] {
      FP32    = 2'd0,
      FP16    = 2'd1,
      FP8     = 2'd2,
      FP16ALT = 2'd3
   } fp_format_e;

   function automatic int unsigned fp_width(input fp_format_e fmt);
      case (fmt)
         FP32:    return 32'd32;
         FP16:    return 32'd16;
         FP8:     return 32'd8;
         FP16ALT: return 32'd16;
         default: return 32'd16;
      endcase
   endfunction

   localparam int unsigned ARRAY_WIDTH         = 32'd12;
   localparam int unsigned X_FEEDER_DW         = 32'd288;
   localparam int unsigned X_FEEDER_CNT_W      = 32'd16;
   localparam int unsigned X_FEEDER_ROWS_W     = $clog2(ARRAY_WIDTH) + 32'd1;
   localparam int unsigned X_FEEDER_COLS_W     = $clog2(X_FEEDER_DW / fp_width(FP16)) + 32'd1;
   localparam int unsigned X_FEEDER_SKID_DEPTH = 32'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } x_feeder_state_e;

   typedef struct packed {
      logic [X_FEEDER_CNT_W-1:0]  n_tiles;
      logic [X_FEEDER_ROWS_W-1:0] rows_lftovr;
      logic [X_FEEDER_COLS_W-1:0] cols_lftovr;
   } x_feeder_cfg_t;

endpackage

// File: rtl/redmule_x_skid.sv
// Two-entry valid/ready skid buffer; pop is ignored when empty.
module redmule_x_skid
   import redmule_x_feeder_pkg::*;
#(
   parameter int unsigned DW = X_FEEDER_DW
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          ready_o,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          empty_o,
   output logic          full_o
);

   logic [DW-1:0] mem_r [X_FEEDER_SKID_DEPTH];
   logic          wr_ptr_r;
   logic          rd_ptr_r;
   logic [1:0]    cnt_r;
   logic          push_s;
   logic          pop_s;

   assign empty_o = (cnt_r == 2'd0);
   assign full_o  = (cnt_r == 2'd2);
   assign ready_o = ~full_o;
   assign pop_s   = pop_i & ~empty_o;
   // A full buffer may still take a beat when the same cycle pops one.
   assign push_s  = valid_i & (~full_o | pop_s);
   assign data_o  = mem_r[rd_ptr_r];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         for (int i = 0; i < int'(X_FEEDER_SKID_DEPTH); i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         cnt_r    <= 2'd0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         if (push_s && !pop_s) begin
            cnt_r <= cnt_r + 2'd1;
         end else if (!push_s && pop_s) begin
            cnt_r <= cnt_r - 2'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

endmodule

// File: rtl/redmule_x_feeder.sv
// X-matrix feeder: skid-buffers stream beats, masks leftover columns and loads the X buffer tile by tile.
// Optional REDMULE_X_FEEDER_PERF_EN adds saturating stall/wait cycle counters.
module redmule_x_feeder
   import redmule_x_feeder_pkg::*;
#(
   parameter int unsigned  DW       = X_FEEDER_DW,
   parameter fp_format_e   FpFormat = FP16,
   parameter int unsigned  Width    = ARRAY_WIDTH,
   parameter int unsigned  CntW     = X_FEEDER_CNT_W,
   localparam int unsigned BITW     = fp_width(FpFormat),
   localparam int unsigned NE       = DW / BITW,
   localparam int unsigned RowsW    = $clog2(Width) + 1,
   localparam int unsigned ColsW    = $clog2(NE) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [CntW-1:0]  n_tiles_i,
   input  logic [RowsW-1:0] rows_lftovr_i,
   input  logic [ColsW-1:0] cols_lftovr_i,
   input  logic             consume_i,
   input  logic             x_valid_i,
   input  logic [DW-1:0]    x_data_i,
   output logic             x_ready_o,
   output logic             load_o,
   output logic [DW-1:0]    x_buffer_o,
   output logic             tile_full_o,
   output logic             busy_o,
`ifdef REDMULE_X_FEEDER_PERF_EN
   output logic [31:0]      stall_cycles_o,
   output logic [31:0]      wait_cycles_o,
`endif
   output logic             done_o
);

   x_feeder_state_e  state_r;
   x_feeder_cfg_t    cfg_r;
   logic [RowsW-1:0] row_cnt_r;
   logic [CntW-1:0]  tile_cnt_r;

   logic [CntW-1:0]  n_tiles_s;
   logic [RowsW-1:0] rows_s;
   logic [ColsW-1:0] cols_s;
   logic [RowsW-1:0] row_lim_s;
   logic [RowsW-1:0] row_nxt_s;
   logic             last_tile_s;
   logic             start_s;
   logic             load_s;
   logic             skid_ready_s;
   logic             skid_empty_s;
   logic             skid_full_s;
   logic             skid_flush_s;
   logic [DW-1:0]    skid_data_s;

   assign n_tiles_s    = CntW'(cfg_r.n_tiles);
   assign rows_s       = RowsW'(cfg_r.rows_lftovr);
   assign cols_s       = ColsW'(cfg_r.cols_lftovr);
   assign last_tile_s  = (tile_cnt_r == (n_tiles_s - CntW'(1'b1)));
   assign row_nxt_s    = row_cnt_r + RowsW'(1'b1);
   assign start_s      = start_i & ((state_r == IDLE) | (state_r == DONE));
   // Leftover beats from a finished job are dropped when the next one starts.
   assign skid_flush_s = clear_i | start_s;
   assign x_ready_o    = skid_ready_s & ((state_r == FILL) | (state_r == WAIT));
   assign load_s       = (state_r == FILL) & ~skid_empty_s;

   assign load_o      = load_s;
   assign tile_full_o = (state_r == WAIT);
   assign busy_o      = (state_r != IDLE);
   assign done_o      = (state_r == DONE);

   redmule_x_skid #(
      .DW (DW)
   ) i_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (skid_flush_s),
      .valid_i (x_valid_i & x_ready_o),
      .data_i  (x_data_i),
      .ready_o (skid_ready_s),
      .pop_i   (load_s),
      .data_o  (skid_data_s),
      .empty_o (skid_empty_s),
      .full_o  (skid_full_s)
   );

   // Row limit: only the last tile may be short.
   always_comb begin
      row_lim_s = RowsW'(Width);
      if (last_tile_s && (rows_s != {RowsW{1'b0}})) begin
         row_lim_s = rows_s;
      end else begin
         row_lim_s = RowsW'(Width);
      end
   end

   // Column-leftover masking of the popped beat.
   always_comb begin
      x_buffer_o = {DW{1'b0}};
      if (load_s) begin
         for (int e = 0; e < int'(NE); e++) begin
            if ((cols_s == {ColsW{1'b0}}) || (ColsW'(e) < cols_s)) begin
               x_buffer_o[e*BITW +: BITW] = skid_data_s[e*BITW +: BITW];
            end else begin
               x_buffer_o[e*BITW +: BITW] = {BITW{1'b0}};
            end
         end
      end else begin
         x_buffer_o = {DW{1'b0}};
      end
   end

   // Control FSM with row and tile counters.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_r    <= IDLE;
         cfg_r      <= '0;
         row_cnt_r  <= {RowsW{1'b0}};
         tile_cnt_r <= {CntW{1'b0}};
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start_i) begin
                  cfg_r.n_tiles     <= X_FEEDER_CNT_W'(n_tiles_i);
                  cfg_r.rows_lftovr <= X_FEEDER_ROWS_W'(rows_lftovr_i);
                  cfg_r.cols_lftovr <= X_FEEDER_COLS_W'(cols_lftovr_i);
                  row_cnt_r         <= {RowsW{1'b0}};
                  tile_cnt_r        <= {CntW{1'b0}};
                  state_r           <= (n_tiles_i == {CntW{1'b0}}) ? DONE : FILL;
               end
            end
            FILL: begin
               if (load_s) begin
                  row_cnt_r <= row_nxt_s;
                  if (row_nxt_s == row_lim_s) begin
                     state_r <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (consume_i) begin
                  row_cnt_r  <= {RowsW{1'b0}};
                  tile_cnt_r <= tile_cnt_r + CntW'(1'b1);
                  state_r    <= last_tile_s ? DONE : FILL;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef REDMULE_X_FEEDER_PERF_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] wait_cnt_r;

   assign stall_cycles_o = stall_cnt_r;
   assign wait_cycles_o  = wait_cnt_r;

   // Saturating starvation and wait-for-consume counters.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i || start_i) begin
         stall_cnt_r <= 32'd0;
         wait_cnt_r  <= 32'd0;
      end else begin
         if ((state_r == FILL) && skid_empty_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if ((state_r == WAIT) && (wait_cnt_r != 32'hFFFF_FFFF)) begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end
`endif

endmodule

// File: tb/tb_redmule_x_feeder.sv
// Directed self-checking bench for redmule_x_feeder (default configuration: DW=288, FP16, W=12).
module tb_redmule_x_feeder;
   import redmule_x_feeder_pkg::*;

   localparam int DW   = 288;
   localparam int NE   = 18;
   localparam int W    = 12;

   logic          clk = 1'b0;
   logic          rst_i, clear_i, start_i, consume_i, x_valid_i;
   logic [15:0]   n_tiles_i;
   logic [4:0]    rows_lftovr_i;
   logic [5:0]    cols_lftovr_i;
   logic [DW-1:0] x_data_i;
   logic          x_ready_o, load_o, tile_full_o, busy_o, done_o;
   logic [DW-1:0] x_buffer_o;
`ifdef REDMULE_X_FEEDER_PERF_EN
   logic [31:0]   stall_cycles_o, wait_cycles_o;
`endif

   always #5 clk = ~clk;

   redmule_x_feeder dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .start_i       (start_i),
      .n_tiles_i     (n_tiles_i),
      .rows_lftovr_i (rows_lftovr_i),
      .cols_lftovr_i (cols_lftovr_i),
      .consume_i     (consume_i),
      .x_valid_i     (x_valid_i),
      .x_data_i      (x_data_i),
      .x_ready_o     (x_ready_o),
      .load_o        (load_o),
      .x_buffer_o    (x_buffer_o),
      .tile_full_o   (tile_full_o),
      .busy_o        (busy_o),
`ifdef REDMULE_X_FEEDER_PERF_EN
      .stall_cycles_o(stall_cycles_o),
      .wait_cycles_o (wait_cycles_o),
`endif
      .done_o        (done_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Beat with sequence id s: element e = s*32+e, or all 0x3C00 in constant mode.
   function automatic logic [DW-1:0] make_beat(input int unsigned s, input bit cmode);
      logic [DW-1:0] b;
      for (int e = 0; e < NE; e++) begin
         b[e*16 +: 16] = cmode ? 16'h3C00 : 16'(s * 32 + e);
      end
      return b;
   endfunction

   bit            stream_en = 1'b0, toggle = 1'b0, cmode = 1'b0, phase = 1'b0, hs_pending = 1'b0;
   int unsigned   seq = 0;
   int            load_cnt = 0;
   logic [DW-1:0] beats[$];

   // Stream source and load monitor, both on the falling edge.
   initial begin
      x_valid_i = 1'b0;
      x_data_i  = '0;
      forever begin
         @(negedge clk);
         if (hs_pending) seq++;
         if (load_o) begin
            load_cnt++;
            beats.push_back(x_buffer_o);
         end
         phase      = ~phase;
         x_valid_i  = stream_en && (!toggle || phase);
         x_data_i   = make_beat(seq, cmode);
         hs_pending = x_valid_i && x_ready_o;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick(3);
      rst_i = 1'b0;
      tick(1);
   endtask

   task automatic do_start(input int n, input int rows, input int cols);
      n_tiles_i     = 16'(n);
      rows_lftovr_i = 5'(rows);
      cols_lftovr_i = 6'(cols);
      start_i       = 1'b1;
      tick(1);
      start_i       = 1'b0;
   endtask

   task automatic do_consume();
      consume_i = 1'b1;
      tick(1);
      consume_i = 1'b0;
   endtask

   task automatic wait_full(input string tag);
      int i = 0;
      while (!tile_full_o && i < 300) begin
         tick(1);
         i++;
      end
      if (!tile_full_o) check({tag, "_timeout"}, tile_full_o, 1);
   endtask

   // Count loaded beats whose id is not one more than the previous one.
   function automatic int seq_gaps();
      int g = 0;
      for (int i = 1; i < beats.size(); i++) begin
         if (beats[i] !== make_beat(beats[0][15:0] / 32 + i, 1'b0)) g++;
      end
      return g;
   endfunction

   int            mark;
   int            errs;
   logic [DW-1:0] exp_b;

   initial begin
      rst_i = 1'b0; clear_i = 1'b0; start_i = 1'b0; consume_i = 1'b0;
      n_tiles_i = '0; rows_lftovr_i = '0; cols_lftovr_i = '0;
      tick(1);
      do_reset();
      check("rst_ready", x_ready_o, 0);
      check("rst_load", load_o, 0);
      check("rst_xbuf", x_buffer_o, 0);
      check("rst_full", tile_full_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);

      // Two full tiles, continuous stream.
      beats.delete(); load_cnt = 0; seq = 0;
      stream_en = 1'b1;
      do_start(2, 0, 0);
      wait_full("t2_full1");
      check("t2_loads1", load_cnt, 12);
      check("t2_tile_full", tile_full_o, 1);
      tick(5);
      check("t2_stall_loads", load_cnt, 12);
      check("t2_stall_load", load_o, 0);
      check("t2_prefetch_full", x_ready_o, 0);
      do_consume();
      wait_full("t2_full2");
      check("t2_loads2", load_cnt, 24);
      tick(3);
      check("t2_stall2", load_cnt, 24);
      do_consume();
      check("t2_done", done_o, 1);
      check("t2_ready_done", x_ready_o, 0);
      check("t2_busy_done", busy_o, 1);
      errs = 0;
      for (int i = 0; i < beats.size(); i++) if (beats[i] !== make_beat(i, 1'b0)) errs++;
      check("t2_seq", errs, 0);
      check("t2_nbeats", beats.size(), 24);

      // Three tiles with a 5-row final tile.
      beats.delete(); mark = load_cnt;
      do_start(3, 5, 0);
      wait_full("t3_full1");
      check("t3_loads1", load_cnt - mark, 12);
      do_consume();
      wait_full("t3_full2");
      check("t3_loads2", load_cnt - mark, 24);
      do_consume();
      wait_full("t3_full3");
      check("t3_loads3", load_cnt - mark, 29);
      tick(2);
      check("t3_not_done_yet", done_o, 0);
      do_consume();
      check("t3_done", done_o, 1);
      check("t3_seq", seq_gaps(), 0);

      // Column leftover of 7 on a constant 0x3C00 beat.
      beats.delete(); mark = load_cnt; cmode = 1'b1;
      do_start(1, 1, 7);
      wait_full("t4_full");
      check("t4_loads", load_cnt - mark, 1);
      exp_b = '0;
      for (int e = 0; e < 7; e++) exp_b[e*16 +: 16] = 16'h3C00;
      check("t4_mask", beats[0], exp_b);
      check("t4_xbuf_idle", x_buffer_o, 0);
      do_consume();
      check("t4_done", done_o, 1);
      cmode = 1'b0;

      // Toggling valid: no lost or duplicated beats.
      beats.delete(); mark = load_cnt; toggle = 1'b1;
      do_start(1, 0, 0);
      wait_full("t5_full");
      check("t5_loads", load_cnt - mark, 12);
      check("t5_seq", seq_gaps(), 0);
      do_consume();
      toggle = 1'b0;

      // Reset in the middle of a fill, then restart from row 0.
      mark = load_cnt;
      do_start(1, 0, 0);
      errs = 0;
      while ((load_cnt - mark) < 6 && errs < 300) begin
         tick(1);
         errs++;
      end
      check("t6_reached_row6", load_cnt - mark, 6);
      rst_i = 1'b1;
      tick(1);
      rst_i = 1'b0;
      check("t6_busy", busy_o, 0);
      check("t6_load", load_o, 0);
      check("t6_ready", x_ready_o, 0);
      check("t6_full", tile_full_o, 0);
      beats.delete(); mark = load_cnt;
      do_start(1, 0, 0);
      wait_full("t6_full2");
      check("t6_reload", load_cnt - mark, 12);
      check("t6_seq", seq_gaps(), 0);

      // Zero tiles and consume pulses in IDLE.
      do_reset();
      do_consume();
      check("t7_idle_busy", busy_o, 0);
      check("t7_idle_full", tile_full_o, 0);
      check("t7_idle_done", done_o, 0);
      mark = load_cnt;
      do_start(0, 0, 0);
      check("t7_done", done_o, 1);
      check("t7_ready", x_ready_o, 0);
      tick(3);
      check("t7_noloads", load_cnt - mark, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
